// File: rtl/amp_pwr_seq_if.sv
// rtl/amp_pwr_seq_if.sv - sequencer control/status bundle for the amp power-up and mute sequencer
//
// Signals:
//   valid      sample strobe from codec_intf (rising edge counted)
//   codec_rdy  CODEC out of reset
//   mute_req   level mute request
//   AMP_ON     amplifier enable
//   gain       12-bit output gain, 0 = silent, 4095 = unity
//   ready      high only while fully on
//   seq_state  current sequencer state for debug/LEDs
// Modports: master drives the requests and observes status, slave is the sequencer.

interface amp_pwr_seq_if;
   logic        valid;
   logic        codec_rdy;
   logic        mute_req;
   logic        AMP_ON;
   logic [11:0] gain;
   logic        ready;
   logic [2:0]  seq_state;

   modport master (
      output valid, codec_rdy, mute_req,
      input  AMP_ON, gain, ready, seq_state
   );

   modport slave (
      input  valid, codec_rdy, mute_req,
      output AMP_ON, gain, ready, seq_state
   );
endinterface

// File: rtl/amp_pwr_seq.sv
// rtl/amp_pwr_seq.sv - power-up, settle, gain-ramp and mute sequencer for the amp output path
//
// Holds the amp off until the CODEC is ready and FILL_CNT samples have passed,
// enables the amp and waits SETTLE_CYC clocks, then ramps gain to full scale by
// RAMP_STEP per sample. Optional macro AMP_SOFT_MUTE_EN selects a ramped mute
// (RAMP_DN) instead of the default hard mute.
//
// Ports:
//   clk    50 MHz system clock
//   rst_n  asynchronous active-low reset
//   bus    amp_pwr_seq_if.slave: valid, codec_rdy, mute_req in;
//          AMP_ON, gain, ready, seq_state out (all registered)

module amp_pwr_seq #(
   parameter int FILL_CNT   = 1536,
   parameter int SETTLE_CYC = 65536,
   parameter int RAMP_STEP  = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   amp_pwr_seq_if.slave bus
);

   localparam int CNT_W = $clog2(FILL_CNT + 1);
   localparam int TMR_W = $clog2(SETTLE_CYC + 1);
   localparam logic [11:0] GAIN_MAX = 12'hFFF;

   typedef enum logic [2:0] {
      WAIT_CODEC = 3'd0,
      FILL       = 3'd1,
      SETTLE     = 3'd2,
      RAMP_UP    = 3'd3,
      ON         = 3'd4,
      RAMP_DN    = 3'd5,
      MUTED      = 3'd6
   } state_t;

   state_t             state_q, state_d;
   logic               valid_q;
   logic               vrise;
   logic [CNT_W-1:0]   sample_cnt_q, sample_cnt_d;
   logic [TMR_W-1:0]   timer_q, timer_d;
   logic [11:0]        gain_q, gain_d;
   logic               amp_on_q, amp_on_d;
   logic               ready_q, ready_d;
   logic [12:0]        gain_up_wide;
   logic [11:0]        gain_up;
`ifdef AMP_SOFT_MUTE_EN
   logic [11:0]        gain_dn;
`endif

   assign vrise = bus.valid & ~valid_q;

   // Up-step is computed one bit wider so the carry out of 4095 saturates
   // instead of wrapping back towards silence.
   assign gain_up_wide = {1'b0, gain_q} + 13'(RAMP_STEP);
   assign gain_up      = gain_up_wide[12] ? GAIN_MAX : gain_up_wide[11:0];
`ifdef AMP_SOFT_MUTE_EN
   assign gain_dn      = ({1'b0, gain_q} > 13'(RAMP_STEP)) ? (gain_q - 12'(RAMP_STEP)) : 12'd0;
`endif

   // State register plus the datapath registers that move with it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= WAIT_CODEC;
         valid_q      <= 1'b0;
         sample_cnt_q <= '0;
         timer_q      <= '0;
      end else begin
         state_q      <= state_d;
         valid_q      <= bus.valid;
         sample_cnt_q <= sample_cnt_d;
         timer_q      <= timer_d;
      end
   end

   // Next state, counters and next gain. A mute transition taken on a vrise
   // cycle suppresses the gain step for that cycle.
   always_comb begin
      state_d      = state_q;
      sample_cnt_d = sample_cnt_q;
      timer_d      = timer_q;
      gain_d       = gain_q;

      if (state_q != WAIT_CODEC && !bus.codec_rdy) begin
         state_d      = WAIT_CODEC;
         sample_cnt_d = '0;
         timer_d      = '0;
         gain_d       = '0;
      end else begin
         case (state_q)
            WAIT_CODEC: begin
               sample_cnt_d = '0;
               timer_d      = '0;
               gain_d       = '0;
               if (bus.codec_rdy)
                  state_d = FILL;
            end
            FILL: begin
               timer_d = '0;
               gain_d  = '0;
               if (vrise) begin
                  sample_cnt_d = sample_cnt_q + CNT_W'(1);
                  if (sample_cnt_q == CNT_W'(FILL_CNT - 1))
                     state_d = SETTLE;
               end
            end
            SETTLE: begin
               gain_d = '0;
               if (timer_q == TMR_W'(SETTLE_CYC - 1)) begin
                  state_d = RAMP_UP;
                  timer_d = '0;
               end else begin
                  timer_d = timer_q + TMR_W'(1);
               end
            end
            RAMP_UP: begin
               if (bus.mute_req) begin
`ifdef AMP_SOFT_MUTE_EN
                  state_d = RAMP_DN;
`else
                  state_d = MUTED;
                  gain_d  = '0;
`endif
               end else if (vrise) begin
                  gain_d = gain_up;
                  if (gain_up == GAIN_MAX)
                     state_d = ON;
               end
            end
            ON: begin
               gain_d = GAIN_MAX;
               if (bus.mute_req) begin
`ifdef AMP_SOFT_MUTE_EN
                  state_d = RAMP_DN;
`else
                  state_d = MUTED;
                  gain_d  = '0;
`endif
               end
            end
            RAMP_DN: begin
`ifdef AMP_SOFT_MUTE_EN
               // Releasing mute resumes the up-ramp from wherever gain is now.
               if (!bus.mute_req) begin
                  state_d = RAMP_UP;
               end else if (vrise) begin
                  gain_d = gain_dn;
                  if (gain_dn == 12'd0)
                     state_d = MUTED;
               end
`else
               // Unreachable with hard mute; fall into MUTED silently.
               state_d = MUTED;
               gain_d  = '0;
`endif
            end
            MUTED: begin
               gain_d = '0;
               if (!bus.mute_req) begin
`ifdef AMP_SOFT_MUTE_EN
                  state_d = RAMP_UP;
`else
                  state_d = ON;
                  gain_d  = GAIN_MAX;
`endif
               end
            end
            default: begin
               state_d      = WAIT_CODEC;
               sample_cnt_d = '0;
               timer_d      = '0;
               gain_d       = '0;
            end
         endcase
      end
   end

   // Output decode from the next state so the registered outputs line up
   // with seq_state (AMP_ON rises on the first SETTLE cycle).
   always_comb begin
      amp_on_d = 1'b0;
      ready_d  = 1'b0;
      case (state_d)
         SETTLE, RAMP_UP, RAMP_DN, MUTED: amp_on_d = 1'b1;
         ON: begin
            amp_on_d = 1'b1;
            ready_d  = 1'b1;
         end
         default: begin
            amp_on_d = 1'b0;
            ready_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gain_q   <= '0;
         amp_on_q <= 1'b0;
         ready_q  <= 1'b0;
      end else begin
         gain_q   <= gain_d;
         amp_on_q <= amp_on_d;
         ready_q  <= ready_d;
      end
   end

   assign bus.AMP_ON    = amp_on_q;
   assign bus.gain      = gain_q;
   assign bus.ready     = ready_q;
   assign bus.seq_state = state_q;

endmodule

// File: tb/tb_amp_pwr_seq.sv
// tb/tb_amp_pwr_seq.sv - directed self-checking bench for amp_pwr_seq

module tb_amp_pwr_seq;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   amp_pwr_seq_if ifc ();

   amp_pwr_seq #(
      .FILL_CNT   (8),
      .SETTLE_CYC (20),
      .RAMP_STEP  (1024)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc.slave)
   );

   always #5 clk = ~clk;

   // {seq_state, AMP_ON, ready, gain}
   logic [16:0] obs;
   assign obs = {ifc.seq_state, ifc.AMP_ON, ifc.ready, ifc.gain};

   function automatic logic [16:0] ev(input logic [2:0] s, input logic a,
                                      input logic r, input logic [11:0] g);
      return {s, a, r, g};
   endfunction

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse();
      ifc.valid = 1'b1;
      @(negedge clk);
      ifc.valid = 1'b0;
   endtask

   // Eight samples through FILL, then the 20-cycle SETTLE window.
   task automatic run_fill_settle(input string tag);
      for (int i = 1; i <= 8; i++) begin
         pulse();
         checks++;
         if (i < 8) begin
            if (obs !== ev(3'd1, 1'b0, 1'b0, 12'd0)) begin
               errors++;
               $display("FAIL %s fill%0d: got %h expected %h", tag, i, obs, ev(3'd1, 1'b0, 1'b0, 12'd0));
            end
            idle(15);
         end else begin
            if (obs !== ev(3'd2, 1'b1, 1'b0, 12'd0)) begin
               errors++;
               $display("FAIL %s settle_entry: got %h expected %h", tag, obs, ev(3'd2, 1'b1, 1'b0, 12'd0));
            end
         end
      end
      idle(19);
      checks++;
      if (obs !== ev(3'd2, 1'b1, 1'b0, 12'd0)) begin
         errors++;
         $display("FAIL %s settle_19: got %h expected %h", tag, obs, ev(3'd2, 1'b1, 1'b0, 12'd0));
      end
      idle(1);
      checks++;
      if (obs !== ev(3'd3, 1'b1, 1'b0, 12'd0)) begin
         errors++;
         $display("FAIL %s settle_20: got %h expected %h", tag, obs, ev(3'd3, 1'b1, 1'b0, 12'd0));
      end
   endtask

   task automatic test_reset();
      ifc.valid     = 1'b0;
      ifc.codec_rdy = 1'b0;
      ifc.mute_req  = 1'b0;
      rst_n         = 1'b1;
      #1 rst_n      = 1'b0;
      idle(3);
      checks++;
      if (obs !== ev(3'd0, 1'b0, 1'b0, 12'd0)) begin
         errors++;
         $display("FAIL reset_state: got %h expected %h", obs, ev(3'd0, 1'b0, 1'b0, 12'd0));
      end
      rst_n = 1'b1;
      idle(1);
      for (int i = 0; i < 20; i++) begin
         pulse();
         checks++;
         if (obs !== ev(3'd0, 1'b0, 1'b0, 12'd0)) begin
            errors++;
            $display("FAIL no_codec%0d: got %h expected %h", i, obs, ev(3'd0, 1'b0, 1'b0, 12'd0));
         end
         idle(15);
      end
   endtask

   task automatic test_fill_settle();
      ifc.codec_rdy = 1'b1;
      idle(1);
      checks++;
      if (obs !== ev(3'd1, 1'b0, 1'b0, 12'd0)) begin
         errors++;
         $display("FAIL enter_fill: got %h expected %h", obs, ev(3'd1, 1'b0, 1'b0, 12'd0));
      end
      run_fill_settle("startup");
   endtask

   task automatic test_ramp_up();
      logic [11:0] eg;
      logic [2:0]  es;
      for (int k = 1; k <= 4; k++) begin
         pulse();
         eg = (k == 4) ? 12'd4095 : 12'(1024 * k);
         es = (k == 4) ? 3'd4 : 3'd3;
         checks++;
         if (obs !== ev(es, 1'b1, k == 4, eg)) begin
            errors++;
            $display("FAIL ramp_up%0d: got %h expected %h", k, obs, ev(es, 1'b1, k == 4, eg));
         end
         idle(15);
      end
   endtask

   task automatic test_mute();
`ifdef AMP_SOFT_MUTE_EN
      logic [11:0] dn_exp [4];
      dn_exp = '{12'd3071, 12'd2047, 12'd1023, 12'd0};
      ifc.mute_req = 1'b1;
      idle(1);
      checks++;
      if (obs !== ev(3'd5, 1'b1, 1'b0, 12'd4095)) begin
         errors++;
         $display("FAIL enter_ramp_dn: got %h expected %h", obs, ev(3'd5, 1'b1, 1'b0, 12'd4095));
      end
      for (int k = 0; k < 4; k++) begin
         pulse();
         checks++;
         if (obs !== ev((k == 3) ? 3'd6 : 3'd5, 1'b1, 1'b0, dn_exp[k])) begin
            errors++;
            $display("FAIL ramp_dn%0d: got %h expected %h", k, obs, ev((k == 3) ? 3'd6 : 3'd5, 1'b1, 1'b0, dn_exp[k]));
         end
         idle(15);
      end
      ifc.mute_req = 1'b0;
      idle(1);
      checks++;
      if (obs !== ev(3'd3, 1'b1, 1'b0, 12'd0)) begin
         errors++;
         $display("FAIL unmute_state: got %h expected %h", obs, ev(3'd3, 1'b1, 1'b0, 12'd0));
      end
      pulse();
      checks++;
      if (obs !== ev(3'd3, 1'b1, 1'b0, 12'd1024)) begin
         errors++;
         $display("FAIL unmute_step: got %h expected %h", obs, ev(3'd3, 1'b1, 1'b0, 12'd1024));
      end
      idle(15);
`else
      ifc.mute_req = 1'b1;
      idle(1);
      checks++;
      if (obs !== ev(3'd6, 1'b1, 1'b0, 12'd0)) begin
         errors++;
         $display("FAIL hard_mute: got %h expected %h", obs, ev(3'd6, 1'b1, 1'b0, 12'd0));
      end
      pulse();
      idle(5);
      checks++;
      if (obs !== ev(3'd6, 1'b1, 1'b0, 12'd0)) begin
         errors++;
         $display("FAIL hard_mute_hold: got %h expected %h", obs, ev(3'd6, 1'b1, 1'b0, 12'd0));
      end
      ifc.mute_req = 1'b0;
      idle(1);
      checks++;
      if (obs !== ev(3'd4, 1'b1, 1'b1, 12'd4095)) begin
         errors++;
         $display("FAIL hard_unmute: got %h expected %h", obs, ev(3'd4, 1'b1, 1'b1, 12'd4095));
      end
      idle(10);
`endif
   endtask

   task automatic test_codec_drop();
      ifc.codec_rdy = 1'b0;
      idle(1);
      checks++;
      if (obs !== ev(3'd0, 1'b0, 1'b0, 12'd0)) begin
         errors++;
         $display("FAIL drop_after_mute: got %h expected %h", obs, ev(3'd0, 1'b0, 1'b0, 12'd0));
      end
      ifc.codec_rdy = 1'b1;
      idle(1);
      run_fill_settle("refill");
      pulse();
      idle(15);
      pulse();
      checks++;
      if (obs !== ev(3'd3, 1'b1, 1'b0, 12'd2048)) begin
         errors++;
         $display("FAIL pre_drop_gain: got %h expected %h", obs, ev(3'd3, 1'b1, 1'b0, 12'd2048));
      end
      idle(3);
      ifc.codec_rdy = 1'b0;
      idle(1);
      checks++;
      if (obs !== ev(3'd0, 1'b0, 1'b0, 12'd0)) begin
         errors++;
         $display("FAIL drop_mid_ramp: got %h expected %h", obs, ev(3'd0, 1'b0, 1'b0, 12'd0));
      end
      ifc.codec_rdy = 1'b1;
      idle(1);
      checks++;
      if (obs !== ev(3'd1, 1'b0, 1'b0, 12'd0)) begin
         errors++;
         $display("FAIL refill_entry: got %h expected %h", obs, ev(3'd1, 1'b0, 1'b0, 12'd0));
      end
      run_fill_settle("refill_full");
   endtask

   task automatic test_async_reset();
      idle(2);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (obs !== ev(3'd0, 1'b0, 1'b0, 12'd0)) begin
         errors++;
         $display("FAIL async_reset: got %h expected %h", obs, ev(3'd0, 1'b0, 1'b0, 12'd0));
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (obs !== ev(3'd1, 1'b0, 1'b0, 12'd0)) begin
         errors++;
         $display("FAIL restart_fill: got %h expected %h", obs, ev(3'd1, 1'b0, 1'b0, 12'd0));
      end
      run_fill_settle("restart");
   endtask

   initial begin
      test_reset();
      test_fill_settle();
      test_ramp_up();
      test_mute();
      test_codec_drop();
      test_ramp_up();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/amp_pwr_seq.md
Name: amp_pwr_seq

Overview:
- Power-up and mute sequencer for the equalizer output path.
- Holds the power amp off until the CODEC is out of reset and the core's sample queues are full, then lets the amp settle.
- After settling, ramps a 12-bit output gain from 0 to full scale, one step per valid sample, to avoid pops.
- Sits beside core and codec_intf. Drives AMP_ON and a gain word that core applies after its volume multiply.

Parameters:
- FILL_CNT, 1536: valid samples to count before the queues are considered steady.
- SETTLE_CYC, 65536: clk cycles between AMP_ON assertion and start of the gain ramp.
- RAMP_STEP, 16: gain increment/decrement per valid sample.

Ports:
- clk  in  1  50MHz system clock.
- rst_n  in  1  asynchronous active-low reset.
- valid  in  1  sample strobe from codec_intf. Only the rising edge is counted.
- codec_rdy  in  1  high once the CODEC is out of reset (RSTn released).
- mute_req  in  1  level; high requests mute.
- AMP_ON  out  1  amplifier enable.
- gain  out  12  output gain, 0 = silent, 4095 = unity.
- ready  out  1  high only in ON.
- seq_state  out  3  current state encoding, for debug/LEDs.

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values:
  - state = WAIT_CODEC; all counters 0.
  - AMP_ON = 0, gain = 0, ready = 0, seq_state = 0.
- vrise = valid & ~valid_q (valid_q is a registered copy of valid). All sample-rate events use vrise.
- State encodings: WAIT_CODEC=0, FILL=1, SETTLE=2, RAMP_UP=3, ON=4, RAMP_DN=5, MUTED=6. All outputs are registered.
- WAIT_CODEC:
  - AMP_ON=0, gain=0.
  - When codec_rdy=1: go to FILL and clear the sample counter.
- FILL:
  - Increment the sample counter on each vrise.
  - On the vrise that brings the count to FILL_CNT: go to SETTLE.
  - The sample counter is $clog2(FILL_CNT+1) bits wide.
- SETTLE:
  - AMP_ON=1 from the first SETTLE cycle; gain=0.
  - The timer counts clk cycles. After SETTLE_CYC cycles: go to RAMP_UP.
- RAMP_UP:
  - On each vrise: gain = min(gain+RAMP_STEP, 4095). Compute in 13 bits, then saturate.
  - When gain reaches 4095: go to ON.
- ON: gain = 4095, ready = 1.
- RAMP_DN:
  - On each vrise: gain = max(gain-RAMP_STEP, 0), with no underflow wrap.
  - When gain reaches 0: go to MUTED. AMP_ON stays 1.
- MUTED: gain = 0, AMP_ON = 1. When mute_req=0: go to RAMP_UP.
- mute_req in RAMP_UP or ON is handled per the optional feature below.
- Priority (highest first):
  1. rst_n.
  2. codec_rdy=0 in any state other than WAIT_CODEC: next cycle state=WAIT_CODEC, AMP_ON=0, gain=0, counters cleared.
  3. mute_req.
  4. vrise.
- mute_req and vrise in the same cycle: the state transition is taken and no gain step is applied that cycle.
- mute_req during WAIT_CODEC, FILL or SETTLE is ignored. It is acted on once RAMP_UP is entered.
- rst_n asserted mid-ramp: outputs go to reset values immediately, without waiting for clk.

Optional Feature:
- Macro: AMP_SOFT_MUTE_EN.
- Defined:
  - mute_req=1 in RAMP_UP or ON: go to RAMP_DN.
  - mute_req=0 in RAMP_DN: go back to RAMP_UP from the current gain.
- Undefined:
  - mute_req=1 in RAMP_UP or ON: next cycle gain=0 and state=MUTED (hard mute). RAMP_DN is unreachable.
  - Release from MUTED: go to ON with gain=4095 the next cycle, no ramp.

Test Plan:
Bench parameters: FILL_CNT=8, SETTLE_CYC=20, RAMP_STEP=1024. valid is pulsed 1 clk every 16 clks unless stated.
1. Reset, codec_rdy=0, 20 valid pulses -> seq_state=0, AMP_ON=0, gain=0 throughout.
2. codec_rdy=1, 8 valid pulses -> cycle after 8th vrise: seq_state=2, AMP_ON=1, gain=0. 20 clks later seq_state=3.
3. Continue valid -> gain 1024, 2048, 3072, then 4095 (saturated), then seq_state=4, ready=1.
4. AMP_SOFT_MUTE_EN defined, mute_req=1 in ON -> gain 3071, 2047, 1023, 0, seq_state=6, AMP_ON=1. Drop mute_req -> gain 1024 on next vrise.
   AMP_SOFT_MUTE_EN undefined -> gain=0 one cycle after mute_req; release -> gain=4095 next cycle.
5. codec_rdy dropped while gain=2048 in RAMP_UP -> next cycle seq_state=0, AMP_ON=0, gain=0. Reassert codec_rdy -> full 8-sample refill required.
6. rst_n pulsed low mid-ON, between clock edges -> AMP_ON=0, gain=0, ready=0 immediately. Restart repeats scenario 2 timing.
